// File: rtl/hqm_core_pkg.sv
// Shared types for the AQED pipe interface monitor.
//
// Contents:
//   err_type_e     - error class reported in the first-error capture (DROP / STABLE / INT)
//   chan_state_e   - per-channel handshake tracker state (IDLE / STALL)
//   ERR_IDX_WIDTH  - width of the first-error index field
package hqm_core_pkg;

  // Encoding is architecturally visible on first_err_type.
  typedef enum logic [1:0] {
    ErrDrop   = 2'd0,
    ErrStable = 2'd1,
    ErrInt    = 2'd2
  } err_type_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StStall = 1'b1
  } chan_state_e;

  localparam int unsigned ERR_IDX_WIDTH = 3;

endpackage : hqm_core_pkg

// File: rtl/hqm_aqed_if_chan_chk.sv
// One valid/ready channel checker for the AQED pipe interface monitor.
//
// Tracks whether the channel is stalled (valid high, ready low) and, while stalled, checks that
// valid stays asserted and data stays stable. Also counts accepts with a saturating counter.
//
// Ports:
//   clk          - clock (hqm_gated_clk)
//   rst          - synchronous active-high reset
//   v            - channel valid
//   ready        - channel ready
//   data         - channel data
//   chk_en       - handshake check enable (takes effect in the same cycle)
//   clr          - clears stickies and the accept counter; state and hold register survive
//   drop_evt     - combinational: valid dropped while stalled this cycle
//   stable_evt   - combinational: data changed while stalled this cycle
//   drop_sticky  - registered sticky of drop_evt
//   stable_sticky- registered sticky of stable_evt
//   acc_cnt      - registered saturating accept counter
module hqm_aqed_if_chan_chk
  import hqm_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  v,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  chk_en,
  input  logic                  clr,
  output logic                  drop_evt,
  output logic                  stable_evt,
  output logic                  drop_sticky,
  output logic                  stable_sticky,
  output logic [CNT_WIDTH-1:0]  acc_cnt
);

  chan_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  drop_sticky_q, drop_sticky_d;
  logic                  stable_sticky_q, stable_sticky_d;
  logic [CNT_WIDTH-1:0]  acc_q, acc_d;
  logic                  accept;

  assign accept = v & ready;

  // Handshake tracker and violation detect.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    drop_evt   = 1'b0;
    stable_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (v && !ready && chk_en) begin
          state_d = StStall;
          hold_d  = data;
        end
      end
      StStall: begin
        if (!chk_en) begin
          // Disabling mid-stall abandons the check silently.
          state_d = StIdle;
        end else if (!v) begin
          drop_evt = 1'b1;
          state_d  = StIdle;
        end else begin
          if (data != hold_q) begin
            stable_evt = 1'b1;
            // Re-arm on the new value so a persistent change is reported once.
            hold_d     = data;
          end
          if (ready) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status and counters; clr wins over any event in the same cycle.
  always_comb begin
    drop_sticky_d   = drop_sticky_q | drop_evt;
    stable_sticky_d = stable_sticky_q | stable_evt;
    acc_d           = acc_q;
    if (accept && (acc_q != {CNT_WIDTH{1'b1}})) begin
      acc_d = acc_q + CNT_WIDTH'(1);
    end
    if (clr) begin
      drop_sticky_d   = 1'b0;
      stable_sticky_d = 1'b0;
      acc_d           = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      hold_q          <= '0;
      drop_sticky_q   <= 1'b0;
      stable_sticky_q <= 1'b0;
      acc_q           <= '0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      drop_sticky_q   <= drop_sticky_d;
      stable_sticky_q <= stable_sticky_d;
      acc_q           <= acc_d;
    end
  end

  assign drop_sticky   = drop_sticky_q;
  assign stable_sticky = stable_sticky_q;
  assign acc_cnt       = acc_q;

endmodule : hqm_aqed_if_chan_chk

// File: rtl/hqm_aqed_pipe_if_monitor.sv
// Runtime monitor for the AQED pipe ingress interfaces. Observation only.
//
// Watches NUM_CH valid/ready channels for handshake violations (valid dropped or data changed
// while stalled) and the pipe interrupt vector for unmasked bits. Reports sticky status, a
// first-error capture and saturating counters. All outputs are registered.
//
// Ports:
//   hqm_gated_clk     - clock
//   hqm_gated_rst     - synchronous active-high reset
//   ch_v / ch_ready   - per-channel valid / ready
//   ch_data           - channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   int_inf_v         - pipe interrupt vector
//   cfg_chk_en        - per-channel handshake check enable
//   cfg_int_mask      - 1 = interrupt bit permitted
//   cfg_clr           - clears stickies, capture and counters (events that cycle discarded)
//   err_drop_sticky   - per channel: valid dropped while stalled
//   err_stable_sticky - per channel: data changed while stalled
//   err_int_sticky    - unmasked interrupt bits seen
//   err_any           - OR of all sticky bits
//   first_err_v/type/idx - first error capture
//   err_cnt           - total error events, saturating
//   acc_cnt           - per-channel accepts, saturating, channel c at [c*CNT_WIDTH +: CNT_WIDTH]
module hqm_aqed_pipe_if_monitor
  import hqm_core_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned INT_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           hqm_gated_clk,
  input  logic                           hqm_gated_rst,
  input  logic [NUM_CH-1:0]              ch_v,
  input  logic [NUM_CH-1:0]              ch_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
  input  logic [INT_WIDTH-1:0]           int_inf_v,
  input  logic [NUM_CH-1:0]              cfg_chk_en,
  input  logic [INT_WIDTH-1:0]           cfg_int_mask,
  input  logic                           cfg_clr,
  output logic [NUM_CH-1:0]              err_drop_sticky,
  output logic [NUM_CH-1:0]              err_stable_sticky,
  output logic [INT_WIDTH-1:0]           err_int_sticky,
  output logic                           err_any,
  output logic                           first_err_v,
  output logic [1:0]                     first_err_type,
  output logic [ERR_IDX_WIDTH-1:0]       first_err_idx,
  output logic [CNT_WIDTH-1:0]           err_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0]    acc_cnt
);

  // Max events per cycle is 2*NUM_CH+1 (DROP and STABLE are exclusive, but size for both).
  localparam int unsigned EvtW = $clog2(2 * NUM_CH + 2);
  localparam int unsigned SumW = CNT_WIDTH + EvtW;
  localparam logic [SumW-1:0] CntMax = {{EvtW{1'b0}}, {CNT_WIDTH{1'b1}}};

  logic [NUM_CH-1:0] drop_evt;
  logic [NUM_CH-1:0] stable_evt;

  // ---------------------------------------------------------------------------------------------
  // Per-channel checkers
  // ---------------------------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    hqm_aqed_if_chan_chk #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_chan_chk (
      .clk           (hqm_gated_clk),
      .rst           (hqm_gated_rst),
      .v             (ch_v[c]),
      .ready         (ch_ready[c]),
      .data          (ch_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .chk_en        (cfg_chk_en[c]),
      .clr           (cfg_clr),
      .drop_evt      (drop_evt[c]),
      .stable_evt    (stable_evt[c]),
      .drop_sticky   (err_drop_sticky[c]),
      .stable_sticky (err_stable_sticky[c]),
      .acc_cnt       (acc_cnt[c*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  // ---------------------------------------------------------------------------------------------
  // Interrupt check
  // ---------------------------------------------------------------------------------------------
  logic [INT_WIDTH-1:0] int_evt_vec;
  logic                 int_evt;
  logic [INT_WIDTH-1:0] int_sticky_q, int_sticky_d;

  assign int_evt_vec = int_inf_v & ~cfg_int_mask;
  assign int_evt     = |int_evt_vec;

  always_comb begin
    int_sticky_d = int_sticky_q | int_evt_vec;
    if (cfg_clr) begin
      int_sticky_d = '0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Event count and saturating error counter
  // ---------------------------------------------------------------------------------------------
  logic [EvtW-1:0]      n_evt;
  logic [SumW-1:0]      err_sum;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    n_evt = EvtW'(int_evt);
    for (int c = 0; c < int'(NUM_CH); c++) begin
      n_evt = n_evt + EvtW'(drop_evt[c]) + EvtW'(stable_evt[c]);
    end
  end

  assign err_sum = {{EvtW{1'b0}}, err_cnt_q} + {{CNT_WIDTH{1'b0}}, n_evt};

  always_comb begin
    if (err_sum > CntMax) begin
      err_cnt_d = {CNT_WIDTH{1'b1}};
    end else begin
      err_cnt_d = err_sum[CNT_WIDTH-1:0];
    end
    if (cfg_clr) begin
      err_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // First-error priority encode: DROP > STABLE > INT, lowest index within a type.
  // Each pass scans high-to-low so the lowest hit wins; later passes have higher priority.
  // ---------------------------------------------------------------------------------------------
  logic                     fe_hit;
  err_type_e                fe_type;
  logic [ERR_IDX_WIDTH-1:0] fe_idx;

  always_comb begin
    fe_hit  = (|drop_evt) | (|stable_evt) | int_evt;
    fe_type = ErrDrop;
    fe_idx  = '0;
    for (int i = int'(INT_WIDTH) - 1; i >= 0; i--) begin
      if (int_evt_vec[i]) begin
        fe_type = ErrInt;
        fe_idx  = ERR_IDX_WIDTH'(i);
      end
    end
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (stable_evt[c]) begin
        fe_type = ErrStable;
        fe_idx  = ERR_IDX_WIDTH'(c);
      end
    end
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (drop_evt[c]) begin
        fe_type = ErrDrop;
        fe_idx  = ERR_IDX_WIDTH'(c);
      end
    end
  end

  logic                     fe_v_q, fe_v_d;
  err_type_e                fe_type_q, fe_type_d;
  logic [ERR_IDX_WIDTH-1:0] fe_idx_q, fe_idx_d;

  always_comb begin
    fe_v_d    = fe_v_q;
    fe_type_d = fe_type_q;
    fe_idx_d  = fe_idx_q;
    if (cfg_clr) begin
      fe_v_d    = 1'b0;
      fe_type_d = ErrDrop;
      fe_idx_d  = '0;
    end else if (!fe_v_q && fe_hit) begin
      fe_v_d    = 1'b1;
      fe_type_d = fe_type;
      fe_idx_d  = fe_idx;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge hqm_gated_clk) begin
    if (hqm_gated_rst) begin
      int_sticky_q <= '0;
      err_cnt_q    <= '0;
      fe_v_q       <= 1'b0;
      fe_type_q    <= ErrDrop;
      fe_idx_q     <= '0;
    end else begin
      int_sticky_q <= int_sticky_d;
      err_cnt_q    <= err_cnt_d;
      fe_v_q       <= fe_v_d;
      fe_type_q    <= fe_type_d;
      fe_idx_q     <= fe_idx_d;
    end
  end

  assign err_int_sticky = int_sticky_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_v    = fe_v_q;
  assign first_err_type = fe_type_q;
  assign first_err_idx  = fe_idx_q;
  // Derived only from registered stickies, so still a registered-timing output.
  assign err_any        = (|err_drop_sticky) | (|err_stable_sticky) | (|int_sticky_q);

endmodule : hqm_aqed_pipe_if_monitor

// File: tb/tb_hqm_aqed_pipe_if_monitor.sv
module tb_hqm_aqed_pipe_if_monitor;

  localparam int NCH = 2;
  localparam int DW  = 64;
  localparam int IW  = 8;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic                hqm_gated_clk = 1'b0;
  logic                hqm_gated_rst;
  logic [NCH-1:0]      ch_v;
  logic [NCH-1:0]      ch_ready;
  logic [NCH*DW-1:0]   ch_data;
  logic [IW-1:0]       int_inf_v;
  logic [NCH-1:0]      cfg_chk_en;
  logic [IW-1:0]       cfg_int_mask;
  logic                cfg_clr;
  logic [NCH-1:0]      err_drop_sticky;
  logic [NCH-1:0]      err_stable_sticky;
  logic [IW-1:0]       err_int_sticky;
  logic                err_any;
  logic                first_err_v;
  logic [1:0]          first_err_type;
  logic [2:0]          first_err_idx;
  logic [CW-1:0]       err_cnt;
  logic [NCH*CW-1:0]   acc_cnt;

  int checks = 0;
  int errors = 0;

  hqm_aqed_pipe_if_monitor #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .INT_WIDTH  (IW),
    .CNT_WIDTH  (CW)
  ) dut (
    .hqm_gated_clk     (hqm_gated_clk),
    .hqm_gated_rst     (hqm_gated_rst),
    .ch_v              (ch_v),
    .ch_ready          (ch_ready),
    .ch_data           (ch_data),
    .int_inf_v         (int_inf_v),
    .cfg_chk_en        (cfg_chk_en),
    .cfg_int_mask      (cfg_int_mask),
    .cfg_clr           (cfg_clr),
    .err_drop_sticky   (err_drop_sticky),
    .err_stable_sticky (err_stable_sticky),
    .err_int_sticky    (err_int_sticky),
    .err_any           (err_any),
    .first_err_v       (first_err_v),
    .first_err_type    (first_err_type),
    .first_err_idx     (first_err_idx),
    .err_cnt           (err_cnt),
    .acc_cnt           (acc_cnt)
  );

  always #5 hqm_gated_clk = ~hqm_gated_clk;

  // Behavioural model: "is the channel mid-handshake" plus the value it promised.
  bit            m_stalled [NCH];
  logic [DW-1:0] m_hold    [NCH];
  int            m_acc     [NCH];
  int            m_err;
  bit [NCH-1:0]  m_drop_s, m_stab_s;
  bit [IW-1:0]   m_int_s;
  bit            m_fe_v;
  int            m_fe_t, m_fe_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int c);
    return ch_data[c*DW +: DW];
  endfunction

  task automatic model_update();
    int drop_lo, stab_lo, int_lo, n;
    bit [IW-1:0] iv;
    if (hqm_gated_rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_stalled[c] = 0; m_hold[c] = '0; m_acc[c] = 0;
      end
      m_err = 0; m_drop_s = '0; m_stab_s = '0; m_int_s = '0;
      m_fe_v = 0; m_fe_t = 0; m_fe_i = 0;
      return;
    end
    drop_lo = -1; stab_lo = -1; int_lo = -1; n = 0;
    iv = int_inf_v & ~cfg_int_mask;
    for (int b = IW - 1; b >= 0; b--) if (iv[b]) int_lo = b;
    if (iv != 0) n++;
    for (int c = NCH - 1; c >= 0; c--) begin
      bit chk, d, s;
      chk = m_stalled[c] && cfg_chk_en[c];
      d = chk && !ch_v[c];
      s = chk && ch_v[c] && (dat(c) != m_hold[c]);
      if (d) begin drop_lo = c; n++; if (!cfg_clr) m_drop_s[c] = 1; end
      if (s) begin stab_lo = c; n++; if (!cfg_clr) m_stab_s[c] = 1; end
      // Stalled next cycle iff enabled and the transfer is still pending.
      if (!m_stalled[c]) begin
        if (ch_v[c] && !ch_ready[c] && cfg_chk_en[c]) m_hold[c] = dat(c);
      end else if (s) begin
        m_hold[c] = dat(c);
      end
      m_stalled[c] = cfg_chk_en[c] && ch_v[c] && !ch_ready[c];
      if (ch_v[c] && ch_ready[c] && m_acc[c] < CMAX) m_acc[c]++;
    end
    if (cfg_clr) begin
      for (int c = 0; c < NCH; c++) m_acc[c] = 0;
      m_err = 0; m_drop_s = '0; m_stab_s = '0; m_int_s = '0;
      m_fe_v = 0; m_fe_t = 0; m_fe_i = 0;
    end else begin
      m_err = (m_err + n > CMAX) ? CMAX : m_err + n;
      m_int_s |= iv;
      if (!m_fe_v && n > 0) begin
        m_fe_v = 1;
        if (drop_lo >= 0)      begin m_fe_t = 0; m_fe_i = drop_lo; end
        else if (stab_lo >= 0) begin m_fe_t = 1; m_fe_i = stab_lo; end
        else                   begin m_fe_t = 2; m_fe_i = int_lo; end
      end
    end
  endtask

  task automatic compare_all();
    check("drop_sticky", 64'(err_drop_sticky), 64'(m_drop_s));
    check("stable_sticky", 64'(err_stable_sticky), 64'(m_stab_s));
    check("int_sticky", 64'(err_int_sticky), 64'(m_int_s));
    check("err_any", 64'(err_any), 64'((m_drop_s != 0) || (m_stab_s != 0) || (m_int_s != 0)));
    check("err_cnt", 64'(err_cnt), 64'(m_err));
    check("first_err_v", 64'(first_err_v), 64'(m_fe_v));
    if (m_fe_v) begin
      check("first_err_type", 64'(first_err_type), 64'(m_fe_t));
      check("first_err_idx", 64'(first_err_idx), 64'(m_fe_i));
    end
    for (int c = 0; c < NCH; c++) check("acc_cnt", 64'(acc_cnt[c*CW +: CW]), 64'(m_acc[c]));
  endtask

  // One clock: model consumes the inputs presented now, outputs compared just after the edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_update();
      @(posedge hqm_gated_clk);
      #1;
      compare_all();
    end
  endtask

  task automatic set_ch(input int c, input bit v, input bit r, input logic [DW-1:0] d);
    ch_v[c] = v;
    ch_ready[c] = r;
    ch_data[c*DW +: DW] = d;
  endtask

  task automatic pulse_clr();
    cfg_clr = 1'b1;
    step();
    cfg_clr = 1'b0;
  endtask

  initial begin
    hqm_gated_rst = 1'b1;
    ch_v = '0; ch_ready = '0; ch_data = '0; int_inf_v = '0;
    cfg_chk_en = '1; cfg_int_mask = '0; cfg_clr = 1'b0;
    #1;
    step(2);
    check("rst err_cnt", 64'(err_cnt), 64'd0);
    check("rst acc_cnt", 64'(acc_cnt), 64'd0);
    check("rst err_any", 64'(err_any), 64'd0);
    hqm_gated_rst = 1'b0;

    // Clean stall then accept.
    set_ch(0, 1, 0, 64'hA5);
    step(3);
    ch_ready[0] = 1'b1;
    step();
    set_ch(0, 0, 0, 64'h0);
    step(2);
    check("t1 err_any", 64'(err_any), 64'd0);
    check("t1 acc0", 64'(acc_cnt[CW-1:0]), 64'd1);

    // Data change while stalled counts once.
    set_ch(1, 1, 0, 64'h10);
    step();
    ch_data[DW +: DW] = 64'h11;
    step(2);
    check("t2 stable", 64'(err_stable_sticky), 64'b10);
    check("t2 err_cnt", 64'(err_cnt), 64'd1);
    check("t2 fe_type", 64'(first_err_type), 64'd1);
    check("t2 fe_idx", 64'(first_err_idx), 64'd1);
    ch_ready[1] = 1'b1;
    step();
    set_ch(1, 0, 0, 64'h0);
    pulse_clr();
    check("t2 clr err_cnt", 64'(err_cnt), 64'd0);
    check("t2 clr acc", 64'(acc_cnt), 64'd0);

    // DROP ch0 + STABLE ch1 + INT in one cycle.
    set_ch(0, 1, 0, 64'h1);
    set_ch(1, 1, 0, 64'h2);
    step();
    set_ch(0, 0, 0, 64'h0);
    ch_data[DW +: DW] = 64'h3;
    int_inf_v = 8'h01;
    step();
    check("t3 err_cnt", 64'(err_cnt), 64'd3);
    check("t3 fe_type", 64'(first_err_type), 64'd0);
    check("t3 fe_idx", 64'(first_err_idx), 64'd0);
    check("t3 int", 64'(err_int_sticky), 64'h01);
    int_inf_v = 8'h00;
    ch_ready[1] = 1'b1;
    step();
    set_ch(1, 0, 0, 64'h0);
    pulse_clr();

    // Masked interrupt bit ignored, lowest unmasked reported.
    cfg_int_mask = 8'h01;
    int_inf_v = 8'h81;
    step();
    int_inf_v = 8'h00;
    step();
    check("t4 int", 64'(err_int_sticky), 64'h80);
    check("t4 fe_type", 64'(first_err_type), 64'd2);
    check("t4 fe_idx", 64'(first_err_idx), 64'd7);
    cfg_int_mask = 8'h00;
    pulse_clr();

    // Saturation, then clear with an event in the clear cycle.
    int_inf_v = 8'h01;
    step(20);
    check("t5 sat", 64'(err_cnt), 64'd15);
    pulse_clr();
    int_inf_v = 8'h00;
    check("t5 clr err_cnt", 64'(err_cnt), 64'd0);
    check("t5 clr any", 64'(err_any), 64'd0);
    check("t5 clr fe_v", 64'(first_err_v), 64'd0);

    // Reset mid-stall: no DROP after release.
    set_ch(0, 1, 0, 64'h55);
    step(2);
    hqm_gated_rst = 1'b1;
    step();
    hqm_gated_rst = 1'b0;
    set_ch(0, 0, 0, 64'h0);
    step(2);
    check("t6 any", 64'(err_any), 64'd0);

    // Disable mid-stall: no event in the disable cycle.
    set_ch(0, 1, 0, 64'h77);
    step();
    cfg_chk_en = 2'b10;
    set_ch(0, 0, 0, 64'h0);
    step();
    cfg_chk_en = 2'b11;
    step();
    check("t7 any", 64'(err_any), 64'd0);

    // Stable beats INT in the same cycle.
    set_ch(1, 1, 0, 64'h5);
    step();
    ch_data[DW +: DW] = 64'h6;
    int_inf_v = 8'h04;
    step();
    int_inf_v = 8'h00;
    ch_ready[1] = 1'b1;
    step();
    check("t8 fe_type", 64'(first_err_type), 64'd1);
    check("t8 err_cnt", 64'(err_cnt), 64'd2);

    // Accept counter saturates (ch1 already has 1 accept).
    step(17);
    check("t8 acc sat", 64'(acc_cnt[2*CW-1:CW]), 64'd15);
    set_ch(1, 0, 0, 64'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hqm_aqed_pipe_if_monitor
